pack_s3: RTL and testbench
==========================

PACK_S3 -- requirements
Module: pack_s3

Interface
REQ-001 SHALL have parameter N_TRITS, default 700: trits per frame (any value from 1 to 4095).
REQ-002 SHALL have port clk, input, 1: clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a frame; honored only in IDLE or DONE.
REQ-005 SHALL have port in_valid, input, 1: in_trit is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a trit this cycle.
REQ-007 SHALL have port in_trit, input, 2: trit encoding 00=0, 01=1, 10=2 (i.e. -1), 11=illegal.
REQ-008 SHALL have port out_valid, output, 1: out_byte is valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts out_byte.
REQ-010 SHALL have port out_byte, output, 8: packed byte.
REQ-011 SHALL have port out_last, output, 1: marks the final byte of the frame; qualified by out_valid.
REQ-012 SHALL have port busy, output, 1: high in RUN and FLUSH.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on entry to DONE.
REQ-014 SHALL have port err, output, 1: sticky illegal-trit flag, cleared by start or rst.

Function
REQ-015 SHALL pack each group of 5 consecutive trits t0..t4 (t0 first in time) into byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4, with range 0..242.
REQ-016 SHALL compute the sum by multiply-free accumulation: acc += t*W[pos], with W = {1,3,9,27,81}, pos cycling 0..4.
REQ-017 SHALL use a 9-bit accumulator internally and emit its low 8 bits.
REQ-018 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-019 SHALL make these transitions: IDLE/DONE -start-> RUN; RUN -> FLUSH after the N_TRITS-th trit is accepted if pos != 0 after that trit; RUN -> DONE when the last byte handshakes; FLUSH -> DONE when the padded byte handshakes.
REQ-020 SHALL accept a trit only when in_valid && in_ready.
REQ-021 SHALL drive in_ready = (state==RUN) && (trit count < N_TRITS) && (!out_valid || out_ready).
REQ-022 SHALL, on acceptance with pos==4, load out_byte from the accumulator plus the current term on the next edge, set out_valid, clear acc, and set pos=0 (latency: 1 cycle from the 5th trit to out_valid).
REQ-023 SHALL hold out_byte and out_last stable while out_valid && !out_ready.
REQ-024 SHALL allow a byte handshake and acceptance of the next trit in the same cycle, giving full throughput of 1 trit per cycle.
REQ-025 SHALL, in FLUSH, treat the missing trits as 0 and emit the partial accumulator as the final byte with out_last=1.
REQ-026 SHALL assert out_last only on byte number ceil(N_TRITS/5) of the frame.
REQ-027 SHALL treat an illegal trit (11) as 0 in the sum and set err.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL, on start from DONE, clear counters, acc and err.
REQ-030 SHALL ignore in_valid outside RUN.

Reset
REQ-031 SHALL, on rst asserted at any time (including mid-frame), set state=IDLE, clear acc, pos and trit count, and drive in_ready=0, out_valid=0, out_byte=0, out_last=0, busy=0, done=0, err=0.
REQ-032 SHALL discard any pending output byte on rst; no partial frame resumes.

Structure
REQ-033 SHALL take from shared package ntru_pkg: N_TRITS default, trit encoding constants (TRIT_0, TRIT_1, TRIT_M1, TRIT_BAD), W weight table, and the pack_state_t enum.
REQ-034 SHALL place the accumulate step (acc, pos, trit -> next acc, byte_complete) in one sub-module, s3_weight_mac.
REQ-035 SHALL keep the FSM, counters and handshake logic in pack_s3.

Verification
REQ-036 SHALL cover: N_TRITS=5, trits 1,2,0,1,1 -> one byte 0x73 (115), out_last=1, done pulse.
REQ-037 SHALL cover: N_TRITS=5, all trits 2 -> 0xF2 (242); all trits 0 -> 0x00.
REQ-038 SHALL cover: N_TRITS=700, random trits, continuous valid/ready -> 140 bytes matching the model, out_last only on byte 140, 700 accepted trits in 700 consecutive cycles.
REQ-039 SHALL cover: N_TRITS=7, trits 1,1,1,1,1,2,1 -> bytes 0x79 (121), then 0x05 via FLUSH with out_last=1.
REQ-040 SHALL cover: out_ready held low for 10 cycles -> out_byte stable, in_ready low after the next group completes, no trit lost.
REQ-041 SHALL cover: trit 11 injected -> err=1 and that trit counts as 0; rst after 300 trits -> all outputs zero, and the next start packs a fresh frame correctly.

Source files
------------

// File: rtl/ntru_pkg.sv
// Shared constants and types for the balanced-ternary packing blocks.
package ntru_pkg;

  localparam int N_TRITS_DEFAULT = 700;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_M1  = 2'b10;
  localparam logic [1:0] TRIT_BAD = 2'b11;

  // Positional weights 3^pos; entry [0] is the weight of the earliest trit.
  localparam logic [4:0][6:0] W = {7'd81, 7'd27, 7'd9, 7'd3, 7'd1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } pack_state_t;

endpackage

// File: rtl/s3_weight_mac.sv
// One accumulate step of the 5-trit packer: acc + trit*3^pos without a multiplier.
module s3_weight_mac
  import ntru_pkg::*;
(
  input  logic [8:0] acc,
  input  logic [2:0] pos,
  input  logic [1:0] trit,
  output logic [8:0] acc_next,
  output logic       byte_complete,
  output logic       trit_bad
);

  logic [6:0] w;
  logic [8:0] term;

  always_comb begin
    case (pos)
      3'd0:    w = W[0];
      3'd1:    w = W[1];
      3'd2:    w = W[2];
      3'd3:    w = W[3];
      3'd4:    w = W[4];
      default: w = 7'd0;
    endcase
    // A "2" trit contributes twice the weight; illegal codes contribute nothing.
    case (trit)
      TRIT_0:  term = 9'd0;
      TRIT_1:  term = {2'b00, w};
      TRIT_M1: term = {1'b0, w, 1'b0};
      default: term = 9'd0;
    endcase
  end

  assign acc_next      = acc + term;
  assign byte_complete = (pos == 3'd4);
  assign trit_bad      = (trit == TRIT_BAD);

endmodule

// File: rtl/pack_s3.sv
// Frame-level packer: 5 trits per byte, zero-padded final byte, valid/ready on both sides.
module pack_s3
  import ntru_pkg::*;
#(
  parameter int N_TRITS = N_TRITS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_trit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = 13;
  localparam logic [CW-1:0] N_LIM = CW'(N_TRITS);

  pack_state_t     state_reg;
  logic [8:0]      acc_reg;
  logic [2:0]      pos_reg;
  logic [CW-1:0]   cnt_reg;

  logic [8:0]      acc_next;
  logic            byte_complete;
  logic            trit_bad;
  logic            accept;
  logic            out_hs;
  logic            last_trit;

  s3_weight_mac u_mac (
    .acc           (acc_reg),
    .pos           (pos_reg),
    .trit          (in_trit),
    .acc_next      (acc_next),
    .byte_complete (byte_complete),
    .trit_bad      (trit_bad)
  );

  assign in_ready  = (state_reg == ST_RUN) && (cnt_reg < N_LIM) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_trit = (cnt_reg == N_LIM - CW'(1));
  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      acc_reg   <= 9'd0;
      pos_reg   <= 3'd0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      // A new byte loaded below overrides this clear, giving back-to-back bytes.
      if (out_hs) out_valid <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg <= ST_RUN;
            acc_reg   <= 9'd0;
            pos_reg   <= 3'd0;
            cnt_reg   <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cnt_reg <= cnt_reg + CW'(1);
            if (trit_bad) err <= 1'b1;
            if (byte_complete) begin
              out_byte  <= acc_next[7:0];
              out_valid <= 1'b1;
              out_last  <= last_trit;
              acc_reg   <= 9'd0;
              pos_reg   <= 3'd0;
            end else begin
              acc_reg <= acc_next;
              pos_reg <= pos_reg + 3'd1;
              if (last_trit) state_reg <= ST_FLUSH;
            end
          end
          if (out_hs && out_last) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // Wait for any full byte still in the output register, then emit the padded one.
          if (!out_valid) begin
            out_byte  <= acc_reg[7:0];
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            acc_reg   <= 9'd0;
            pos_reg   <= 3'd0;
          end else if (out_hs && out_last) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_s3.sv
// Self-checking bench for pack_s3: directed table, randomized frames vs. arithmetic model.
module tb_pack_s3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [3];
  logic       in_valid  [3];
  logic       out_ready [3];
  logic [1:0] in_trit   [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic [7:0] out_byte  [3];
  logic       out_last  [3];
  logic       busy      [3];
  logic       done      [3];
  logic       err       [3];

  always #5 clk = ~clk;

  pack_s3 #(.N_TRITS(5)) u_n5 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_trit(in_trit[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_byte(out_byte[0]), .out_last(out_last[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
  );
  pack_s3 #(.N_TRITS(7)) u_n7 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_trit(in_trit[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_byte(out_byte[1]), .out_last(out_last[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
  );
  pack_s3 #(.N_TRITS(700)) u_n700 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_trit(in_trit[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_byte(out_byte[2]), .out_last(out_last[2]), .busy(busy[2]), .done(done[2]), .err(err[2])
  );

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [1:0] trits[$];
  logic [7:0] got_bytes[$];
  bit         got_last[$];
  int done_cnt, acc_cnt, first_acc, last_acc, stall_cyc, hold_viol, rdy_viol;

  typedef struct {
    int         k;
    logic [1:0] t [7];
    int         nb;
    int         b0;
    int         b1;
    int         e;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] rnd_trit(input bit allow_bad);
    return allow_bad ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
  endfunction

  // mode 0: always ready; 1: random ready; 2: ready held low for 10 cycles of the first byte.
  task automatic run_frame(input int k, input int mode);
    int idx = 0;
    int cyc = 0;
    int stall_left = 10;
    bit fin = 0;
    bit prev_hold = 0;
    logic [7:0] prev_b = 8'd0;
    logic prev_l = 1'b0;
    got_bytes.delete();
    got_last.delete();
    done_cnt = 0; acc_cnt = 0; first_acc = -1; last_acc = -1;
    stall_cyc = 0; hold_viol = 0; rdy_viol = 0;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    while (!fin && cyc < 5000) begin
      in_valid[k] = (idx < trits.size());
      in_trit[k]  = (idx < trits.size()) ? trits[idx] : 2'b00;
      case (mode)
        0:       out_ready[k] = 1'b1;
        1:       out_ready[k] = 1'($urandom_range(0, 1));
        default: out_ready[k] = (stall_left == 0);
      endcase
      @(negedge clk);
      if (prev_hold && (!out_valid[k] || out_byte[k] != prev_b || out_last[k] != prev_l))
        hold_viol++;
      if (out_valid[k] && !out_ready[k]) begin
        stall_cyc++;
        if (in_ready[k]) rdy_viol++;
      end
      if (mode == 2 && out_valid[k] && stall_left > 0) stall_left--;
      prev_hold = out_valid[k] && !out_ready[k];
      prev_b = out_byte[k];
      prev_l = out_last[k];
      if (in_valid[k] && in_ready[k]) begin
        idx++;
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (out_valid[k] && out_ready[k]) begin
        got_bytes.push_back(out_byte[k]);
        got_last.push_back(out_last[k]);
      end
      if (done[k]) begin
        done_cnt++;
        fin = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    if (!fin) $display("FAIL frame_timeout: got no done after %0d cycles expected done", cyc);
    chk("frame_finished", fin, 1);
    @(negedge clk);
    chk("done_one_cycle", done[k], 0);
    @(posedge clk); #1;
  endtask

  // Reference: base-3 digits, earliest trit least significant, illegal treated as 0, zero padded.
  task automatic check_frame(input string nm, input int k);
    int exp_b[$];
    int n, s, w, v, j, nlast;
    bit exp_err = 0;
    n = trits.size();
    for (int g = 0; g < (n + 4) / 5; g++) begin
      s = 0; w = 1;
      for (int i = 0; i < 5; i++) begin
        j = g * 5 + i;
        v = 0;
        if (j < n) v = (trits[j] == 2'd1) ? 1 : (trits[j] == 2'd2) ? 2 : 0;
        s += v * w;
        w *= 3;
      end
      exp_b.push_back(s);
    end
    foreach (trits[i]) if (trits[i] == 2'd3) exp_err = 1;
    chk({nm, "_nbytes"}, got_bytes.size(), exp_b.size());
    for (int i = 0; i < got_bytes.size() && i < exp_b.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), got_bytes[i], exp_b[i]);
    nlast = 0;
    foreach (got_last[i]) nlast += got_last[i];
    chk({nm, "_last_count"}, nlast, 1);
    if (got_last.size() > 0) chk({nm, "_last_on_final"}, got_last[got_last.size()-1], 1);
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_err"}, err[k], exp_err);
    $display("frame %s: %0d trits, %0d bytes, err=%0d", nm, n, got_bytes.size(), err[k]);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; in_valid[k] = 1'b0; in_trit[k] = 2'b00; out_ready[k] = 1'b1;
    end
    #12;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_outputs_%0d", k),
          {in_ready[k], out_valid[k], out_byte[k], out_last[k], busy[k], done[k], err[k]}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: {instance, trits, byte count, expected bytes, expected err}.
    tbl[0] = '{k: 0, t: '{1, 2, 0, 1, 1, 0, 0}, nb: 1, b0: 115, b1: 0, e: 0};
    tbl[1] = '{k: 0, t: '{2, 2, 2, 2, 2, 0, 0}, nb: 1, b0: 242, b1: 0, e: 0};
    tbl[2] = '{k: 0, t: '{0, 0, 0, 0, 0, 0, 0}, nb: 1, b0: 0,   b1: 0, e: 0};
    tbl[3] = '{k: 1, t: '{1, 1, 1, 1, 1, 2, 1}, nb: 2, b0: 121, b1: 5, e: 0};
    tbl[4] = '{k: 0, t: '{3, 1, 3, 3, 3, 0, 0}, nb: 1, b0: 3,   b1: 0, e: 1};
    tbl[5] = '{k: 1, t: '{2, 2, 2, 2, 2, 2, 2}, nb: 2, b0: 242, b1: 8, e: 0};
    tbl[6] = '{k: 0, t: '{1, 0, 0, 0, 0, 0, 0}, nb: 1, b0: 1,   b1: 0, e: 0};
    for (int v = 0; v < 7; v++) begin
      trits.delete();
      for (int i = 0; i < ((tbl[v].k == 0) ? 5 : 7); i++) trits.push_back(tbl[v].t[i]);
      run_frame(tbl[v].k, v % 2);
      chk($sformatf("tbl%0d_nbytes", v), got_bytes.size(), tbl[v].nb);
      if (got_bytes.size() > 0) chk($sformatf("tbl%0d_b0", v), got_bytes[0], tbl[v].b0);
      if (tbl[v].nb == 2 && got_bytes.size() > 1) chk($sformatf("tbl%0d_b1", v), got_bytes[1], tbl[v].b1);
      if (got_last.size() > 0) chk($sformatf("tbl%0d_last", v), got_last[got_last.size()-1], 1);
      chk($sformatf("tbl%0d_done", v), done_cnt, 1);
      chk($sformatf("tbl%0d_err", v), err[tbl[v].k], tbl[v].e);
      $display("table vector %0d: %0d bytes, first 0x%02h", v, got_bytes.size(),
               (got_bytes.size() > 0) ? got_bytes[0] : 8'h00);
    end

    // Random short frames with illegal codes and random backpressure.
    for (int f = 0; f < 30; f++) begin
      trits.delete();
      for (int i = 0; i < 7; i++) trits.push_back(rnd_trit(1));
      run_frame(1, 1);
      check_frame($sformatf("rnd7_%0d", f), 1);
    end

    // Full-length frame at full throughput.
    trits.delete();
    for (int i = 0; i < 700; i++) trits.push_back(rnd_trit(0));
    run_frame(2, 0);
    check_frame("full700", 2);
    chk("full700_accepted", acc_cnt, 700);
    chk("full700_consecutive", last_acc - first_acc, 699);

    // Backpressure: first byte stalled for 10 cycles.
    trits.delete();
    for (int i = 0; i < 700; i++) trits.push_back(rnd_trit(0));
    run_frame(2, 2);
    check_frame("stall700", 2);
    chk("stall_cycles", stall_cyc, 10);
    chk("stall_byte_stable", hold_viol, 0);
    chk("stall_in_ready_low", rdy_viol, 0);
    chk("stall_accepted", acc_cnt, 700);

    // Reset mid-frame after 300 trits (one illegal), then a fresh frame.
    trits.delete();
    for (int i = 0; i < 700; i++) trits.push_back((i == 10) ? 2'd3 : rnd_trit(0));
    start[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 1000 && acc_cnt < 300; c++) begin
      in_valid[2] = 1'b1;
      in_trit[2]  = trits[acc_cnt];
      @(negedge clk);
      if (in_ready[2]) acc_cnt++;
      @(posedge clk); #1;
    end
    in_valid[2] = 1'b0;
    chk("pre_reset_accepted", acc_cnt, 300);
    @(negedge clk);
    chk("pre_reset_busy", busy[2], 1);
    chk("pre_reset_err", err[2], 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outputs",
        {in_ready[2], out_valid[2], out_byte[2], out_last[2], busy[2], done[2], err[2]}, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset applied after %0d trits", acc_cnt);
    trits.delete();
    for (int i = 0; i < 700; i++) trits.push_back(rnd_trit(0));
    run_frame(2, 1);
    check_frame("after_reset", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
